button_event_arbiter: RTL

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter_pkg.sv | 19 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/button_event_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/button_event_arbiter_pkg.sv
// Shared constants for the button/filter blocks.
//   DEF_SIGNAL_BIT_WIDTH : default number of request lines
//   DEF_FIFO_DEPTH       : default event queue depth
//   clog2()              : ceiling log2, used to size codes, pointers and counts
package button_event_arbiter_pkg;

   localparam int DEF_SIGNAL_BIT_WIDTH = 8;
   localparam int DEF_FIFO_DEPTH       = 4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count.
//   clk, reset_n : clock, async active-low reset (clears pointers and count)
//   push, din    : write din when not full
//   pop          : drop the head entry when not empty
//   dout         : head entry, forced to zero while empty
//   full, empty  : derived from the registered count (no same-cycle pass-through)
//   count        : number of stored entries
module sync_fifo
   import button_event_arbiter_pkg::*;
#(
   parameter  int DATA_W = 3,
   parameter  int DEPTH  = DEF_FIFO_DEPTH,
   localparam int PTR_W  = clog2(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              do_push, do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage needs no reset: it is only visible through dout while non-empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/button_event_arbiter.sv
// Collects active-low one-cycle button pulses into a pending register,
// grants one pending button per cycle round-robin and queues its index.
//   clk, reset_n          : clock, async active-low reset
//   signals_onepulsed_n   : active-low request pulses, one bit per button
//   event_ready           : consumer pops the head event when event_valid
//   clear_dropped         : synchronous clear of the dropped flag
//   event_valid/code      : queue non-empty / index of the head button
//   event_count           : number of queued events
//   dropped               : sticky, a press was merged into a pending one
module button_event_arbiter
   import button_event_arbiter_pkg::*;
#(
   parameter  int SIGNAL_BIT_WIDTH = DEF_SIGNAL_BIT_WIDTH,
   parameter  int FIFO_DEPTH       = DEF_FIFO_DEPTH,
   localparam int CODE_W           = clog2(SIGNAL_BIT_WIDTH),
   localparam int CNT_W            = clog2(FIFO_DEPTH) + 1
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [SIGNAL_BIT_WIDTH-1:0] signals_onepulsed_n,
   input  logic                        event_ready,
   input  logic                        clear_dropped,
   output logic                        event_valid,
   output logic [CODE_W-1:0]           event_code,
   output logic [CNT_W-1:0]            event_count,
   output logic                        dropped
);

   localparam int W = SIGNAL_BIT_WIDTH;

   logic [W-1:0]      pulse, pending, grant_oh;
   logic [CODE_W-1:0] rr_ptr, grant_idx;
   logic              found, full, empty, push, pop, drop_now;

   assign pulse       = ~signals_onepulsed_n;
   assign event_valid = !empty;
   assign pop         = event_valid && event_ready;
   assign push        = found && !full;

   // First pending bit at or after rr_ptr, wrapping modulo W.
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      grant_oh  = '0;
      for (int i = 0; i < W; i++) begin
         int j;
         j = (int'(rr_ptr) + i) % W;
         if (!found && pending[CODE_W'(j)]) begin
            found     = 1'b1;
            grant_idx = CODE_W'(j);
         end
      end
      if (push) grant_oh[grant_idx] = 1'b1;
   end

   // A pulse on the bit being granted survives as a new request; a pulse on a
   // bit that stays pending is merged and counts as a drop.
   assign drop_now = |(pulse & pending & ~grant_oh);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending <= '0;
         rr_ptr  <= '0;
         dropped <= 1'b0;
      end else begin
         pending <= (pending & ~grant_oh) | pulse;
         dropped <= (dropped && !clear_dropped) || drop_now;
         if (push)
            rr_ptr <= (grant_idx == CODE_W'(W - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   sync_fifo #(
      .DATA_W (CODE_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (grant_idx),
      .dout    (event_code),
      .full    (full),
      .empty   (empty),
      .count   (event_count)
   );

endmodule
